// File: rtl/vga_timing_rx.sv
// vga_timing_rx: receive-side raster timing recovery.
//
// Takes an incoming hsync/vsync/de stream in the pixel clock domain and does three things:
// recovers px/py coordinates for each active pixel, measures line and frame geometry, and
// declares format lock once the measured geometry matches the expected mode for LOCK_FRAMES
// consecutive frames. Every output appears two clocks after the input pins.
//
// Ports
//   clk_i            pixel clock
//   rst_ni           asynchronous active-low reset
//   hsync_i          horizontal sync, active level HS_POL
//   vsync_i          vertical sync, active level VS_POL
//   de_i             data enable, active-high
//   px_o / py_o      column / row of the current active pixel
//   pix_valid_o      px_o/py_o qualify a pixel
//   frame_start_o    one-cycle pulse on a vsync leading edge
//   h_total_meas_o   clocks between the last two hsync leading edges
//   h_active_meas_o  de-high clocks in the last completed line
//   v_total_meas_o   lines in the last completed frame
//   v_active_meas_o  active lines in the last completed frame
//   locked_o         format lock
//   fmt_err_o        one-cycle pulse: mismatch detected while locked
module vga_timing_rx #(
  parameter int unsigned H_ACTIVE_EXP = 640,
  parameter int unsigned H_TOTAL_EXP  = 800,
  parameter int unsigned V_ACTIVE_EXP = 480,
  parameter int unsigned V_TOTAL_EXP  = 525,
  parameter bit          HS_POL       = 1'b0,
  parameter bit          VS_POL       = 1'b0,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        de_i,
  output logic [9:0]  px_o,
  output logic [9:0]  py_o,
  output logic        pix_valid_o,
  output logic        frame_start_o,
  output logic [11:0] h_total_meas_o,
  output logic [11:0] h_active_meas_o,
  output logic [11:0] v_total_meas_o,
  output logic [11:0] v_active_meas_o,
  output logic        locked_o,
  output logic        fmt_err_o
);

  localparam logic [11:0] HTotExp  = 12'(H_TOTAL_EXP);
  localparam logic [11:0] HActExp  = 12'(H_ACTIVE_EXP);
  localparam logic [11:0] VTotExp  = 12'(V_TOTAL_EXP);
  localparam logic [11:0] VActExp  = 12'(V_ACTIVE_EXP);
  // h_cnt_q at this value means the next clock would make it reach 2 * H_TOTAL_EXP.
  localparam logic [11:0] TmoLimit = 12'(2 * H_TOTAL_EXP - 1);
  localparam logic [2:0]  LockCnt  = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Input stage: syncs are normalised to "1 = active" on the way in.
  logic hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q, de_s1_q, de_s2_q;
  logic hs_edge, vs_edge, de_rise, de_fall;

  // Coordinates.
  logic [9:0] px_q, px_d, py_q, py_d;
  logic       pix_valid_q, first_pend_q, first_pend_d;

  // Measurement.
  logic [11:0] h_cnt_q, h_cnt_d, a_cnt_q, a_cnt_d, l_cnt_q, l_cnt_d, al_cnt_q, al_cnt_d;
  logic [11:0] h_tot_q, h_tot_d, h_act_q, h_act_d, v_tot_q, v_tot_d, v_act_q, v_act_d;
  logic [11:0] l_cnt_inc, al_cnt_inc;
  logic        frame_start_q;

  // Lock FSM.
  state_e     state_q, state_d;
  logic [2:0] mcnt_q, mcnt_d, mcnt_inc;
  logic       match, tmo;
  logic       fmt_err_q, fmt_err_d;

  assign hs_edge = hs_s1_q & ~hs_s2_q;
  assign vs_edge = vs_s1_q & ~vs_s2_q;
  assign de_rise = de_s1_q & ~de_s2_q;
  assign de_fall = ~de_s1_q & de_s2_q;

  // Coordinate recovery.
  always_comb begin
    px_d         = px_q;
    py_d         = py_q;
    first_pend_d = first_pend_q;
    if (de_rise) begin
      px_d         = '0;
      py_d         = (first_pend_q || vs_edge) ? 10'd0 : py_q + 10'd1;
      first_pend_d = 1'b0;
    end else begin
      if (de_s1_q) px_d = px_q + 10'd1;
      if (vs_edge) first_pend_d = 1'b1;
    end
  end

  // Line and frame measurement.
  always_comb begin
    h_cnt_d    = hs_edge ? 12'd0 : sat_inc(h_cnt_q);
    h_tot_d    = hs_edge ? sat_inc(h_cnt_q) : h_tot_q;
    a_cnt_d    = a_cnt_q;
    h_act_d    = h_act_q;
    if (de_fall) begin
      h_act_d = a_cnt_q;
      a_cnt_d = '0;
    end else if (de_s1_q) begin
      a_cnt_d = sat_inc(a_cnt_q);
    end
    // Edges coincident with the vsync edge are counted into the frame that is ending.
    l_cnt_inc  = hs_edge ? sat_inc(l_cnt_q) : l_cnt_q;
    al_cnt_inc = de_rise ? sat_inc(al_cnt_q) : al_cnt_q;
    v_tot_d    = v_tot_q;
    v_act_d    = v_act_q;
    l_cnt_d    = l_cnt_inc;
    al_cnt_d   = al_cnt_inc;
    if (vs_edge) begin
      v_tot_d  = l_cnt_inc;
      v_act_d  = al_cnt_inc;
      l_cnt_d  = '0;
      al_cnt_d = '0;
    end
  end

  // The _d values are exactly what gets latched this cycle, including the latest line values.
  assign match = (h_tot_d == HTotExp) && (h_act_d == HActExp) &&
                 (v_tot_d == VTotExp) && (v_act_d == VActExp);
  assign tmo   = (h_cnt_q >= TmoLimit) && !hs_edge;
  assign mcnt_inc = mcnt_q + 3'd1;

  // Lock FSM: next state.
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    if (tmo) begin
      state_d = StSearch;
      mcnt_d  = '0;
    end else if (vs_edge) begin
      unique case (state_q)
        StSearch: begin
          // The frame in progress at acquisition is partial, so it is never compared.
          state_d = StVerify;
          mcnt_d  = '0;
        end
        StVerify: begin
          if (match) begin
            mcnt_d = mcnt_inc;
            if (mcnt_inc >= LockCnt) state_d = StLocked;
          end else begin
            mcnt_d = '0;
          end
        end
        StLocked: begin
          if (!match) begin
            state_d = StVerify;
            mcnt_d  = '0;
          end
        end
        default: begin
          state_d = StSearch;
          mcnt_d  = '0;
        end
      endcase
    end
  end

  // Lock FSM: outputs.
  always_comb begin
    fmt_err_d = (state_q == StLocked) && vs_edge && !match && !tmo;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_s1_q       <= 1'b0;
      hs_s2_q       <= 1'b0;
      vs_s1_q       <= 1'b0;
      vs_s2_q       <= 1'b0;
      de_s1_q       <= 1'b0;
      de_s2_q       <= 1'b0;
      px_q          <= '0;
      py_q          <= '0;
      pix_valid_q   <= 1'b0;
      first_pend_q  <= 1'b0;
      h_cnt_q       <= '0;
      a_cnt_q       <= '0;
      l_cnt_q       <= '0;
      al_cnt_q      <= '0;
      h_tot_q       <= '0;
      h_act_q       <= '0;
      v_tot_q       <= '0;
      v_act_q       <= '0;
      frame_start_q <= 1'b0;
      state_q       <= StSearch;
      mcnt_q        <= '0;
      fmt_err_q     <= 1'b0;
    end else begin
      hs_s1_q       <= (hsync_i == HS_POL);
      hs_s2_q       <= hs_s1_q;
      vs_s1_q       <= (vsync_i == VS_POL);
      vs_s2_q       <= vs_s1_q;
      de_s1_q       <= de_i;
      de_s2_q       <= de_s1_q;
      px_q          <= px_d;
      py_q          <= py_d;
      pix_valid_q   <= de_s1_q;
      first_pend_q  <= first_pend_d;
      h_cnt_q       <= h_cnt_d;
      a_cnt_q       <= a_cnt_d;
      l_cnt_q       <= l_cnt_d;
      al_cnt_q      <= al_cnt_d;
      h_tot_q       <= h_tot_d;
      h_act_q       <= h_act_d;
      v_tot_q       <= v_tot_d;
      v_act_q       <= v_act_d;
      frame_start_q <= vs_edge;
      state_q       <= state_d;
      mcnt_q        <= mcnt_d;
      fmt_err_q     <= fmt_err_d;
    end
  end

  assign px_o            = px_q;
  assign py_o            = py_q;
  assign pix_valid_o     = pix_valid_q;
  assign frame_start_o   = frame_start_q;
  assign h_total_meas_o  = h_tot_q;
  assign h_active_meas_o = h_act_q;
  assign v_total_meas_o  = v_tot_q;
  assign v_active_meas_o = v_act_q;
  assign locked_o        = (state_q == StLocked);
  assign fmt_err_o       = fmt_err_q;

endmodule

// File: doc/vga_timing_rx.md
Name: vga_timing_rx

Overview:
- Receive-side counterpart of the pixel-timing generator: consumes a raster stream (hsync, vsync, de) in the 25 MHz pixel domain.
- Recovers per-pixel coordinates px/py and measures line/frame geometry.
- Declares lock when the measured format matches the expected mode for consecutive frames.
- Sits in front of any overlay or analysis logic that needs coordinates from an incoming video stream. Example: loopback checking of the HDMI output path.

Parameters:
- H_ACTIVE_EXP, 640, expected active pixels per line
- H_TOTAL_EXP, 800, expected clocks per line
- V_ACTIVE_EXP, 480, expected active lines per frame
- V_TOTAL_EXP, 525, expected lines per frame
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- LOCK_FRAMES, 2, consecutive matching frames required for lock (1..7)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- hsync  in  1  horizontal sync, polarity per HS_POL
- vsync  in  1  vertical sync, polarity per VS_POL
- de  in  1  data enable / video_active, active-high
- px  out  10  column of current active pixel
- py  out  10  row of current active pixel
- pix_valid  out  1  px/py qualify a pixel (registered de)
- frame_start  out  1  one-cycle pulse on vsync leading edge
- h_total_meas  out  12  clocks between last two hsync leading edges
- h_active_meas  out  12  de-high clocks in last completed line
- v_total_meas  out  12  lines in last completed frame
- v_active_meas  out  12  active lines in last completed frame
- locked  out  1  format lock
- fmt_err  out  1  one-cycle pulse: mismatch detected while locked

Behaviour:
Reset:
- All outputs 0; FSM in SEARCH; all counters 0.
- rst_n low mid-frame clears everything immediately (async); operation resumes in SEARCH.

Input stage:
- hsync/vsync/de registered once (s1), then again (s2).
- Leading edge = s1 at active level and s2 not. de rise/fall likewise.
- All outputs have 2-cycle latency from input pins.

Pixel coordinates:
- pix_valid = de_s1 delayed one cycle.
- On de rise: px=0. While de stays high: px+1 per clock.
- py: first de rise after a vsync leading edge sets py=0; each later de rise sets py+1.
- px and py hold their value while de is low.
- px and py wrap at 1023 (no saturation).

Measurement:
- All counters are 12-bit and saturate at 4095.
- h_cnt increments every clock. On hsync leading edge: h_total_meas <= h_cnt+1, then h_cnt <= 0.
- a_cnt counts de-high clocks. On de fall: h_active_meas <= a_cnt, a_cnt <= 0.
- l_cnt counts hsync leading edges; al_cnt counts de rises.
- On vsync leading edge: v_total_meas <= l_cnt, v_active_meas <= al_cnt, both counters reset to 0.
- A coincident hsync edge in the same cycle is counted into the ending frame.
- frame_start pulses in the same cycle as the vsync latch.

Lock FSM, evaluated on vsync leading edges:
- Match = all four values being latched that cycle equal the expected parameters. For h_total/h_active the latest latched line value is used.
- SEARCH: first vsync edge goes to VERIFY with mcnt=0. This first partial frame is never compared.
- VERIFY, on vsync edge:
  - match: mcnt+1; when mcnt reaches LOCK_FRAMES go to LOCKED and set locked=1.
  - mismatch: mcnt=0, stay in VERIFY.
- LOCKED, on vsync edge:
  - mismatch: fmt_err pulse, locked=0, go to VERIFY with mcnt=0.
  - match: stay in LOCKED.
- Timeout: h_cnt reaching 2*H_TOTAL_EXP in any state forces SEARCH, locked=0, mcnt=0. No fmt_err pulse on timeout. Measurement outputs hold their last values.

Test Plan:
- Reset: clean 640x480 stream from the existing sync generator -> locked=0 until the 3rd vsync leading edge after reset; locked=1 two cycles after that edge. Measurements read 800/640/525/480.
- Coordinates: locked stream -> first pix_valid pixel of frame has px=0, py=0; last has px=639, py=479. pix_valid high for exactly 307200 clocks per frame.
- Format change: while locked, lengthen one frame to 526 lines -> fmt_err pulses once at that frame's vsync edge, v_total_meas=526, locked=0. Relock after LOCK_FRAMES further clean frames.
- Timeout: hold hsync inactive while locked -> locked falls 1600 clocks after the last hsync edge, no fmt_err. Restarting the stream relocks after 3 vsync edges.
- Reset mid-operation: assert rst_n low mid-line while locked -> all outputs 0 asynchronously. After release, behaviour matches the first scenario.
- Polarity: HS_POL=1, VS_POL=1 with inverted syncs -> identical lock timing and measurements to the first scenario.
